uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter: accepts bytes over a ready/valid handshake into a small FIFO and serializes them 8N1 on a single-wire line at a fixed baud rate. It is the transmitting end of the serial link whose receiving end is the board's FPGA_SERIAL_RX path. It sits on the CPU clock domain and drives a pin such as FPGA_SERIAL_TX, or a loopback into the CPU's receive pin in simulation.

## Interface
Parameters:
- CLOCK_FREQ, 71_428_571: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- DEPTH, 8: FIFO entries; must be a power of 2 and ≥ 2.
- Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer-truncated. The default is 620 cycles/bit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to transmit.
- data_in_valid  in  1  data_in holds a byte to enqueue.
- data_in_ready  out  1  FIFO can accept a byte this cycle.
- serial_out  out  1  UART line; idle high.
- tx_busy  out  1  serializer is mid-frame.
- fifo_count  out  $clog2(DEPTH)+1  bytes currently queued, excluding the byte being shifted.

## Operation
- Push: a byte is accepted on any edge where data_in_valid && data_in_ready.
  - data_in_ready = (fifo_count < DEPTH). It is combinational from registered count.
  - There is no push-through when full, even if a pop occurs on the same edge.
- FIFO: circular buffer with wrapping read/write pointers and a separate count register.
  - Simultaneous push and pop leaves the count unchanged.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count > 0, pop the head into an 8-bit shift register and go to START. Otherwise stay in IDLE.
  - START: serial_out = 0 for SYMBOL_EDGE_TIME cycles, then go to DATA with bit index 0.
  - DATA: serial_out = shift[0], bits sent LSB first. Each bit is held SYMBOL_EDGE_TIME cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: serial_out = 1 for SYMBOL_EDGE_TIME cycles. On the last cycle, if fifo_count > 0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Bit timing: a symbol counter counts 0..SYMBOL_EDGE_TIME-1 and is cleared on every state or bit transition.
- Outputs:
  - serial_out is registered and is 1 in IDLE.
  - tx_busy = (state != IDLE).
- Data integrity: bytes are emitted in acceptance order, with no loss or duplication.

## Timing
- Reset (asynchronous, takes effect immediately):
  - serial_out = 1, tx_busy = 0, fifo_count = 0, state IDLE.
  - Pointers and counters are cleared.
  - data_in_ready = 1 while reset is asserted and after it is released.
- Reset mid-frame: the line returns high at once, the frame is truncated, and queued bytes are discarded. There is no resumption after release.
- Latency with the FIFO empty and the FSM in IDLE:
  - Handshake on edge k: fifo_count = 1 after edge k.
  - Pop on edge k+1: serial_out falls and tx_busy rises after edge k+1.
- Frame length: exactly 10 × SYMBOL_EDGE_TIME cycles from the falling start edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Full FIFO: data_in_ready = 0 from the edge where count reaches DEPTH. It returns to 1 on the edge after the next pop.
- Wrap-around: pointers wrap modulo DEPTH, and order is preserved across the wrap.

## Test plan
Tests 1–5 use CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles/bit), DEPTH=4.
1. Single byte: push 0xA5 from idle.
   - serial_out falls 1 cycle after the handshake edge.
   - Bits sampled mid-symbol read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop).
   - tx_busy is high for exactly 100 cycles.
2. Burst and back-pressure: hold valid high with 0x01..0x06.
   - data_in_ready drops after 5 bytes are accepted (1 popped, 4 queued).
   - It rises again after the first frame completes.
   - All 6 bytes appear in order with no idle cycles between frames.
3. Wrap-around: stream 12 bytes (0x10..0x1B) with random valid gaps.
   - The received sequence matches exactly, and fifo_count never exceeds 4.
4. Simultaneous push and pop:
   - Push on the same edge as the STOP→START pop: fifo_count is unchanged and the byte order is correct.
   - Push exactly when count=4: the byte is not accepted.
5. Reset mid-frame: assert rst during DATA bit 3 of 0xFF with 2 bytes queued.
   - serial_out = 1 immediately and fifo_count = 0.
   - After release, the line stays high indefinitely with no input.
6. Default parameters: receive one byte 0x3C through the CPU's UART receiver in loopback.
   - Bit period is 620 cycles, and the receiver reports 0x3C.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: ready/valid bytes enter a circular FIFO and are
// shifted out LSB first at CLOCK_FREQ/BAUD_RATE clock cycles per bit.
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 71_428_571,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic                   serial_out,
    output logic                   tx_busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CW-1:0] DEPTH_V  = CW'(DEPTH);
    localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    state_t        state, state_next;
    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [SW-1:0] sym_cnt, sym_cnt_next;
    logic          sym_done, serial_next;

    assign data_in_ready = (fifo_count < DEPTH_V);
    assign push          = data_in_valid && data_in_ready;
    assign sym_done      = (sym_cnt == SYM_LAST);
    assign tx_busy       = (state != IDLE);

    // NOTE: byte storage has no reset; the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        sym_cnt_next = sym_cnt + 1'b1;
        pop          = 1'b0;
        serial_next  = 1'b1;

        unique case (state)
            IDLE: begin
                sym_cnt_next = '0;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (sym_done) begin
                    sym_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (sym_done) begin
                    sym_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sym_done) begin
                    sym_cnt_next = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase

        // The line level is registered from the state being entered.
        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            default: serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            sym_cnt    <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_idx    <= bit_idx_next;
            sym_cnt    <= sym_cnt_next;
            serial_out <= serial_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a 10-cycle/bit, depth-4 instance checked against a
// line receiver and byte queues, plus a default-parameter instance in loopback.
module tb_uart_tx_buffered;
    localparam int T     = 10;
    localparam int DEF_T = 620;

    logic       clk, rst;
    logic [7:0] data_in;
    logic       data_in_valid, data_in_ready, serial_out, tx_busy;
    logic [2:0] fifo_count;
    logic [7:0] d_data;
    logic       d_valid, d_ready, d_serial, d_busy;
    logic [3:0] d_count;

    uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy),
        .fifo_count(fifo_count)
    );

    uart_tx_buffered dut_def (
        .clk(clk), .rst(rst), .data_in(d_data), .data_in_valid(d_valid),
        .data_in_ready(d_ready), .serial_out(d_serial), .tx_busy(d_busy),
        .fifo_count(d_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [9:0] rx_q[$];
    int         rx_start_q[$];
    logic [7:0] exp_q[$];

    logic [9:0] mon_bits;
    int         mon_t;
    bit         mon_active;

    int g, busy_cycles, n_acc, stall_acc, rise_cyc, max_cnt, s_cyc, low_cnt, low_run, idx;
    bit acc_now, seen_high;
    logic [9:0] frame6;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Receiver for the small instance: samples mid-symbol, records each frame
    // as {stop, data[7:0], start} and the cycle its start bit was seen.
    initial begin
        mon_active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (serial_out === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t      = 0;
                    mon_bits   = '0;
                    rx_start_q.push_back(cyc);
                end
            end else begin
                mon_t++;
                if (mon_t % T == T / 2) begin
                    mon_bits = {serial_out, mon_bits[9:1]};
                    if (mon_t == 9 * T + T / 2) begin
                        rx_q.push_back(mon_bits);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int w = 0;
        data_in       = b;
        data_in_valid = 1'b1;
        while (!data_in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        exp_q.push_back(b);
        check("push_wait", w < 1000, 1);
    endtask

    task automatic wait_frames(input int n);
        int w = 0;
        while ((rx_q.size() < n || tx_busy) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("frame_wait", w < 3000, 1);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_frame%0d", tag, i), rx_q[i], frame_of(exp_q[i]));
    endtask

    task automatic clear_queues();
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_start();
        int w = 0;
        while (rx_start_q.size() == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("start_seen", rx_start_q.size() > 0, 1);
    endtask

    initial begin
        rst = 1'b1; data_in = '0; data_in_valid = 1'b0; d_data = '0; d_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial", serial_out, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", data_in_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single byte from idle
        data_in = 8'hA5; data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        exp_q.push_back(8'hA5);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_line_before_pop", serial_out, 1);
        @(negedge clk);
        check("t1_line_fall", serial_out, 0);
        check("t1_busy_rise", tx_busy, 1);
        check("t1_count_after_pop", fifo_count, 0);
        busy_cycles = 0;
        while (tx_busy && busy_cycles < 300) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("t1_busy_cycles", busy_cycles, 10 * T);
        wait_frames(1);
        check_frames("t1");

        // 2: burst with back-pressure
        clear_queues();
        data_in = 8'h01; data_in_valid = 1'b1;
        n_acc = 0; g = 0; stall_acc = -1; rise_cyc = -1;
        while (n_acc < 6 && g < 3000) begin
            acc_now = data_in_ready;
            @(negedge clk);
            g++;
            if (acc_now) begin
                exp_q.push_back(data_in);
                n_acc++;
                data_in = 8'(n_acc + 1);
            end
            if (!data_in_ready && stall_acc < 0) stall_acc = n_acc;
            if (data_in_ready && stall_acc >= 0 && rise_cyc < 0) rise_cyc = cyc;
        end
        data_in_valid = 1'b0;
        check("t2_stall_after", stall_acc, 5);
        check("t2_ready_rise_at_frame_end", rise_cyc - rx_start_q[0], 10 * T);
        wait_frames(6);
        check_frames("t2");
        for (int i = 1; i < 6; i++)
            check($sformatf("t2_gap%0d", i), rx_start_q[i] - rx_start_q[i-1], 10 * T);

        // 3: wrap-around with random valid gaps
        clear_queues();
        idx = 0; g = 0; max_cnt = 0;
        while (idx < 12 && g < 5000) begin
            data_in       = 8'(8'h10 + idx);
            data_in_valid = ($urandom_range(0, 3) != 0);
            acc_now       = data_in_valid && data_in_ready;
            @(negedge clk);
            g++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (acc_now) begin
                exp_q.push_back(data_in);
                idx++;
            end
        end
        data_in_valid = 1'b0;
        check("t3_all_accepted", idx, 12);
        check("t3_max_count_ok", max_cnt <= 4, 1);
        wait_frames(12);
        check_frames("t3");

        // 4: push on the STOP->START pop edge, then push into a full FIFO
        clear_queues();
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        wait_start();
        s_cyc = rx_start_q[0];
        while (cyc < s_cyc + 10 * T - 1) @(negedge clk);
        data_in = 8'h44; data_in_valid = 1'b1;
        exp_q.push_back(8'h44);
        @(negedge clk);
        data_in_valid = 1'b0;
        check("t4_count_push_pop", fifo_count, 2);
        check("t4_back_to_back", serial_out, 0);
        push_byte(8'h45); push_byte(8'h46);
        check("t4_full_count", fifo_count, 4);
        check("t4_full_ready", data_in_ready, 0);
        data_in = 8'h47; data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        check("t4_full_no_accept", fifo_count, 4);
        wait_frames(6);
        repeat (2 * T) @(negedge clk);
        check_frames("t4");

        // 5: reset mid-frame during data bit 3
        clear_queues();
        push_byte(8'hFF); push_byte(8'h01); push_byte(8'h02);
        wait_start();
        s_cyc = rx_start_q[0];
        while (cyc < s_cyc + 4 * T + 3) @(negedge clk);
        check("t5_pre_count", fifo_count, 2);
        check("t5_pre_busy", tx_busy, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_serial", serial_out, 1);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_ready", data_in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        low_cnt = 0; busy_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) low_cnt++;
            if (tx_busy !== 1'b0) busy_cycles++;
        end
        check("t5_line_stays_high", low_cnt, 0);
        check("t5_stays_idle", busy_cycles, 0);
        check("t5_no_frames", rx_q.size(), 0);

        // 6: default parameters, one byte through a behavioural receiver
        d_data = 8'h3C; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        g = 0;
        while (d_serial !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("t6_start_seen", d_serial, 0);
        low_run = 0; seen_high = 1'b0; frame6 = '0;
        for (int t = 0; t < 10 * DEF_T; t++) begin
            if (!seen_high && d_serial === 1'b0) low_run++;
            else seen_high = 1'b1;
            if (t % DEF_T == DEF_T / 2) frame6 = {d_serial, frame6[9:1]};
            @(negedge clk);
        end
        // 0x3C sends start, 0, 0 before its first 1: three bit periods low.
        check("t6_bit_period_x3", low_run, 3 * DEF_T);
        check("t6_rx_frame", frame6, frame_of(8'h3C));
        check("t6_idle_after", d_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
